opram_loader: RTL and testbench
===============================

Name: opram_loader

Overview:
- Program-image writer for the instruction RAM; it is the write side of opram_control, whose write port the CPU core leaves tied off.
- Accepts a framed byte stream over a valid/ready handshake, writes the op bytes sequentially into opram, and verifies an XOR checksum.
- Gates the CPU: `cpu_run` is asserted only after a successful load, so the pc and other CPU blocks run only after a clean image is in RAM.

Parameters:
- DATA_W, 8, width of op bytes, length byte and checksum byte.
- ADDR_W, 8, opram address width.
- DEPTH, 256, opram capacity in ops; maximum legal frame length.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- in_data  in  DATA_W  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader can accept a byte.
- wr_en  out  1  opram write strobe; drives opram_control.write.
- wr_addr  out  ADDR_W  opram write address.
- wr_data  out  DATA_W  opram write data; drives opram_control.writeop.
- busy  out  1  load frame in progress.
- cpu_run  out  1  image loaded and verified; CPU may run.
- err  out  1  last load failed (bad length or checksum).

Behaviour:
- Reset (rst=0, async): state=IDLE; address counter=0; remaining count=0; checksum accumulator=0.
  - All outputs are 0: in_ready, wr_en, wr_addr, wr_data, busy, cpu_run, err.
- Frame format: LEN byte, then N op bytes, then CHK byte.
  - LEN=0 encodes N=DEPTH (256).
  - CHK must equal the XOR of the N op bytes only; LEN is excluded.
- Handshake: a byte is accepted in a cycle where in_valid & in_ready are both 1 at the clk rising edge.
  - in_ready is a registered state decode: 1 in LEN, DATA and CHK; 0 elsewhere.
  - in_valid is ignored whenever in_ready=0.
- FSM states: IDLE, LEN, DATA, CHK, DONE, ERR.
- IDLE:
  - start -> LEN. On entry, clear the address counter, the XOR accumulator, err and cpu_run; set busy=1.
- LEN, on accept:
  - N>DEPTH -> ERR.
  - Otherwise load remaining=N -> DATA.
- DATA, on accept:
  - Next cycle: wr_en=1 for exactly one cycle, wr_addr=current address, wr_data=byte. This is 1-cycle registered write latency.
  - Same edge: XOR the byte into the accumulator, increment the address, decrement remaining.
  - When the byte accepted brings remaining to 0 -> CHK.
  - At most one accept per cycle, so back-to-back accepts give back-to-back write strobes.
- CHK, on accept:
  - byte == accumulator -> DONE.
  - Otherwise -> ERR.
- DONE: busy=0, cpu_run=1, err=0. start -> LEN, and cpu_run drops on the same edge.
- ERR: busy=0, cpu_run=0, err=1. start -> LEN, and err clears on entry.
- Address wrap: the counter is ADDR_W bits and wraps 255->0.
  - With N=DEPTH=256, the last write is to address 255.
  - The wrap to 0 occurs only after the final increment and is never used.
- start in LEN, DATA or CHK is ignored; the load continues.
- start and an accept in the same cycle in DONE/ERR: no accept is possible because in_ready=0, so the frame begins on the following byte.
- Reset asserted mid-frame: immediate return to reset values. Any partial image left in RAM is not trusted; cpu_run stays 0 until the next successful load.
- wr_en is never asserted outside the cycle following a DATA accept.

Decomposition:
- Shared package `gcore_pkg` holds:
  - localparams for the state encodings (IDLE=0, LEN=1, DATA=2, CHK=3, DONE=4, ERR=5);
  - GCORE_DATA_W=8;
  - GCORE_ADDR_W=8;
  - GCORE_OPRAM_DEPTH=256.
- One sub-module, `xor_accum`: a DATA_W XOR accumulator with clear and enable, clk and async active-low rst. It is reused for the checksum.
- The FSM, counters and write register stay in opram_loader.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, then 1 -> all outputs 0; in_valid=1 with no start leaves in_ready=0 and produces no wr_en.
- Nominal 4-op load: start, then LEN=04, ops 12,34,56,78, CHK=08 -> wr_en pulses at addr 0..3 with data 12,34,56,78 in order; after the CHK accept, cpu_run=1, busy=0, err=0.
- Checksum error: same frame with CHK=09 -> all 4 writes occur, then err=1 and cpu_run=0; a following start clears err.
- Full-depth load and backpressure: LEN=00, 256 ops with value=index, random in_valid gaps -> 256 writes at addr 0..255, no duplicate or missed strobes; CHK=00 -> DONE.
- Length error: with DEPTH=16, LEN=20 -> ERR immediately with no wr_en; a start during DATA of a later valid frame has no effect.
- Reset mid-frame: async rst=0 after 2 of 4 ops -> outputs go to 0 without waiting for a clk edge; a new full frame then loads correctly from addr 0.

Source files
------------

// File: rtl/gcore_pkg.sv
// Shared definitions for the core: datapath sizes and the loader state encoding.
package gcore_pkg;
    localparam int GCORE_DATA_W      = 8;
    localparam int GCORE_ADDR_W      = 8;
    localparam int GCORE_OPRAM_DEPTH = 256;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LEN  = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_CHK  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        LEN  = ST_LEN,
        DATA = ST_DATA,
        CHK  = ST_CHK,
        DONE = ST_DONE,
        ERR  = ST_ERR
    } state_t;
endpackage

// File: rtl/xor_accum.sv
// Running XOR accumulator with synchronous clear (clear wins over enable).
module xor_accum #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      q <= '0;
        else if (clr)  q <= '0;
        else if (en)   q <= q ^ d;
    end
endmodule

// File: rtl/opram_loader.sv
// Framed program-image writer for opram: LEN, N op bytes, XOR checksum.
// cpu_run is raised only after a frame whose checksum matched.
module opram_loader
    import gcore_pkg::*;
#(
    parameter int DATA_W = GCORE_DATA_W,
    parameter int ADDR_W = GCORE_ADDR_W,
    parameter int DEPTH  = GCORE_OPRAM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              cpu_run,
    output logic              err
);
    // One extra bit so a LEN of 0 can carry the full 2**DATA_W count.
    localparam int              CNT_W   = DATA_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  addr;
    logic [CNT_W-1:0]   remain;
    logic [CNT_W-1:0]   len_n;
    logic [DATA_W-1:0]  chk;
    logic               accept;
    logic               enter_len;
    logic               data_acc;

    assign accept    = in_valid & in_ready;
    assign len_n     = (in_data == '0) ? DEPTH_C : CNT_W'(in_data);
    assign data_acc  = (state == DATA) && accept;
    assign enter_len = (state_nxt == LEN) && (state != LEN);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_nxt = LEN;
            LEN:             if (accept) state_nxt = (len_n > DEPTH_C) ? ERR : DATA;
            DATA:            if (accept && remain == CNT_W'(1)) state_nxt = CHK;
            CHK:             if (accept) state_nxt = (in_data == chk) ? DONE : ERR;
            default:         state_nxt = IDLE;
        endcase
    end

    // Status outputs are registered decodes of the next state, so they line up with state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            addr     <= '0;
            remain   <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            cpu_run  <= 1'b0;
            err      <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            state    <= state_nxt;
            in_ready <= state_nxt inside {LEN, DATA, CHK};
            busy     <= state_nxt inside {LEN, DATA, CHK};
            cpu_run  <= (state_nxt == DONE);
            err      <= (state_nxt == ERR);
            wr_en    <= data_acc;

            if (enter_len)     addr <= '0;
            else if (data_acc) addr <= addr + 1'b1;

            if (state == LEN && accept) remain <= len_n;
            else if (data_acc)          remain <= remain - 1'b1;

            if (data_acc) begin
                wr_addr <= addr;
                wr_data <= in_data;
            end
        end
    end

    xor_accum #(.W(DATA_W)) u_chk (
        .clk (clk),
        .rst (rst),
        .clr (enter_len),
        .en  (data_acc),
        .d   (in_data),
        .q   (chk)
    );
endmodule

// File: tb/tb_opram_loader.sv
// Randomised bench for opram_loader: a full-depth instance and a 16-deep instance,
// each checked against a frame-level model of the expected writes and final status.
module tb_opram_loader;
    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [1:0]      start    = '0;
    logic [1:0]      in_valid = '0;
    logic [1:0][7:0] in_data  = '0;
    logic [1:0]      in_ready, wr_en, busy, cpu_run, err;
    logic [1:0][7:0] wr_addr, wr_data;

    int checks = 0;
    int errors = 0;
    logic [7:0]  ops[$];
    logic [15:0] wq0[$], wq1[$];

    always #5 clk = ~clk;

    opram_loader #(.DATA_W(8), .ADDR_W(8), .DEPTH(256)) dut (
        .clk(clk), .rst(rst), .start(start[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
        .busy(busy[0]), .cpu_run(cpu_run[0]), .err(err[0]));

    opram_loader #(.DATA_W(8), .ADDR_W(8), .DEPTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
        .busy(busy[1]), .cpu_run(cpu_run[1]), .err(err[1]));

    always @(negedge clk) begin
        if (wr_en[0]) wq0.push_back({wr_addr[0], wr_data[0]});
        if (wr_en[1]) wq1.push_back({wr_addr[1], wr_data[1]});
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    function automatic logic [7:0] xor_ops(input int n);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < n; i++) x ^= ops[i];
        return x;
    endfunction

    task automatic fill_ops(input int n);
        ops.delete();
        for (int i = 0; i < n; i++) ops.push_back(8'($urandom));
    endtask

    task automatic pulse_start(input int s);
        start[s] = 1'b1;
        @(posedge clk); #1;
        start[s] = 1'b0;
    endtask

    task automatic send_byte(input int s, input logic [7:0] b, input int gapmax);
        int n = 0;
        bit done = 0;
        repeat ($urandom_range(gapmax, 0)) begin
            in_data[s] = 8'($urandom);
            @(posedge clk); #1;
        end
        in_data[s]  = b;
        in_valid[s] = 1'b1;
        while (!done && n <= 60) begin
            @(negedge clk);
            if (in_ready[s]) begin
                @(posedge clk); #1;
                done = 1;
            end
            n++;
        end
        in_valid[s] = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL handshake dut%0d: byte %h not accepted within 60 cycles", s, b);
        end
    endtask

    // Drives one frame and checks it against the frame rules: N from LEN (0 -> depth),
    // writes of ops[i] to address i when N fits, DONE only if CHK is the XOR of the ops.
    task automatic run_frame(input int s, input logic [7:0] len, input logic [7:0] chk,
                             input int gapmax, input bit mid_start);
        int          depth, n;
        bit          len_ok, ok;
        logic [15:0] exp[$];
        logic [15:0] got[$];
        depth  = (s == 0) ? 256 : 16;
        n      = (len == 8'h00) ? depth : int'(len);
        len_ok = (n <= depth);
        if (len_ok) for (int i = 0; i < n; i++) exp.push_back({8'(i), ops[i]});
        ok = len_ok && (chk == xor_ops(len_ok ? n : 0));
        if (s == 0) wq0.delete(); else wq1.delete();

        pulse_start(s);
        checks++;
        if ({busy[s], in_ready[s], cpu_run[s], err[s]} !== 4'b1100) begin
            errors++;
            $display("FAIL start_entry dut%0d: busy/rdy/run/err=%b want 1100", s,
                     {busy[s], in_ready[s], cpu_run[s], err[s]});
        end

        send_byte(s, len, gapmax);
        if (len_ok) begin
            for (int i = 0; i < n; i++) begin
                send_byte(s, ops[i], gapmax);
                if (mid_start && i == 1) begin
                    pulse_start(s);
                    checks++;
                    if ({busy[s], in_ready[s]} !== 2'b11) begin
                        errors++;
                        $display("FAIL mid_start dut%0d: busy/rdy=%b want 11", s, {busy[s], in_ready[s]});
                    end
                end
            end
            send_byte(s, chk, gapmax);
        end
        @(posedge clk); #1;
        @(negedge clk);

        got = (s == 0) ? wq0 : wq1;
        checks++;
        if (got.size() !== exp.size()) begin
            errors++;
            $display("FAIL write_count dut%0d len=%h: got %0d want %0d", s, len, got.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++)
                if (got[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL write_seq dut%0d idx %0d: addr/data got %h want %h", s, i, got[i], exp[i]);
                    break;
                end
        end
        checks++;
        if ({busy[s], in_ready[s], wr_en[s], cpu_run[s], err[s]} !== {3'b000, ok, !ok}) begin
            errors++;
            $display("FAIL final_status dut%0d len=%h: busy/rdy/wr/run/err=%b want %b", s, len,
                     {busy[s], in_ready[s], wr_en[s], cpu_run[s], err[s]}, {3'b000, ok, !ok});
        end
    endtask

    task automatic test_reset;
        int rdy_seen = 0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if ({in_ready[s], wr_en[s], wr_addr[s], wr_data[s], busy[s], cpu_run[s], err[s]} !== 21'd0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: rdy=%b wr=%b addr=%h data=%h busy=%b run=%b err=%b want all 0",
                         s, in_ready[s], wr_en[s], wr_addr[s], wr_data[s], busy[s], cpu_run[s], err[s]);
            end
        end
        @(posedge clk); #1;
        wq0.delete();
        in_valid[0] = 1'b1;
        in_data[0]  = 8'hA5;
        repeat (5) begin
            @(negedge clk);
            if (in_ready[0]) rdy_seen++;
        end
        in_valid[0] = 1'b0;
        checks++;
        if (rdy_seen != 0 || wq0.size() != 0) begin
            errors++;
            $display("FAIL idle_ignore: ready cycles %0d writes %0d want 0 0", rdy_seen, wq0.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_nominal;
        ops = '{8'h12, 8'h34, 8'h56, 8'h78};
        run_frame(0, 8'h04, 8'h08, 0, 0);
    endtask

    task automatic test_checksum_err;
        ops = '{8'h12, 8'h34, 8'h56, 8'h78};
        run_frame(0, 8'h04, 8'h09, 1, 0);
    endtask

    task automatic test_full_depth;
        ops.delete();
        for (int i = 0; i < 256; i++) ops.push_back(8'(i));
        run_frame(0, 8'h00, 8'h00, 3, 0);
    endtask

    task automatic test_length_err;
        fill_ops(5);
        run_frame(1, 8'h20, 8'h00, 0, 0);
        run_frame(1, 8'h05, xor_ops(5), 1, 1);
        fill_ops(16);
        run_frame(1, 8'h00, xor_ops(16), 1, 0);
    endtask

    task automatic test_random;
        for (int k = 0; k < 8; k++) begin
            int s = k % 2;
            int len = (s == 0) ? int'($urandom_range(40, 1)) : int'($urandom_range(24, 0));
            int n = (len == 0) ? ((s == 0) ? 256 : 16) : len;
            logic [7:0] c;
            fill_ops(n);
            c = ($urandom_range(1, 0) == 1) ? xor_ops(n) : 8'($urandom);
            run_frame(s, 8'(len), c, 2, ($urandom_range(1, 0) == 1) && n > 2);
        end
    endtask

    task automatic test_reset_mid;
        fill_ops(4);
        wq0.delete();
        pulse_start(0);
        send_byte(0, 8'h04, 0);
        send_byte(0, ops[0], 0);
        send_byte(0, ops[1], 0);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({in_ready[0], wr_en[0], wr_addr[0], wr_data[0], busy[0], cpu_run[0], err[0]} !== 21'd0) begin
            errors++;
            $display("FAIL async_reset: rdy=%b wr=%b addr=%h data=%h busy=%b run=%b err=%b want all 0",
                     in_ready[0], wr_en[0], wr_addr[0], wr_data[0], busy[0], cpu_run[0], err[0]);
        end
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #1;
        fill_ops(4);
        run_frame(0, 8'h04, xor_ops(4), 1, 0);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_checksum_err();
        test_full_depth();
        test_length_err();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
